// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and datapath widths.
package cpu_pkg;

    localparam int unsigned ADDR_WIDTH  = 8;
    localparam int unsigned INSTR_WIDTH = 16;

    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        HOLD     = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: reads the opcode and operand bytes of a 16-bit instruction
// from byte-wide memory, holds the result for the decoder, and pulses the
// program counter enable on the decoder handshake.
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   pc_address_i,
    output logic                    pc_enable_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    input  logic                    mem_ready_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic [2*DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]   instr_addr_o,
    output logic                    instr_valid_o,
    input  logic                    instr_ready_i
);
    import cpu_pkg::*;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;

    // Next state and byte/address latches; the PC is sampled only on the first byte.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        case (state_q)
            FETCH_HI: begin
                if (mem_ready_i) begin
                    fetch_addr_d = pc_address_i;
                    hi_d         = mem_rdata_i;
                    state_d      = FETCH_LO;
                end
            end
            FETCH_LO: begin
                if (mem_ready_i) begin
                    lo_d    = mem_rdata_i;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // mem_ready is ignored here; only the decoder handshake leaves HOLD.
                if (instr_ready_i) begin
                    state_d = FETCH_HI;
                end
            end
            default: state_d = FETCH_HI;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH_HI;
            fetch_addr_q <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    // Memory request decode; reset gates the request so an in-flight read is abandoned at once.
    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
        if (!reset) begin
            case (state_q)
                FETCH_HI: begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = pc_address_i;
                end
                FETCH_LO: begin
                    mem_req_o  = 1'b1;
                    // Wraps modulo 2^ADDR_WIDTH.
                    mem_addr_o = fetch_addr_q + ADDR_WIDTH'(1);
                end
                default: begin
                    mem_req_o  = 1'b0;
                    mem_addr_o = '0;
                end
            endcase
        end
    end

    // Decoder-side outputs.
    always_comb begin
        instr_valid_o = (state_q == HOLD);
        pc_enable_o   = instr_valid_o && instr_ready_i;
        instr_o       = {hi_q, lo_q};
        instr_addr_o  = fetch_addr_q;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program counter and the instruction decoder. It reads the two bytes of each 16-bit instruction from byte-wide instruction memory over a request/ready handshake and presents the assembled instruction to the decoder over valid/ready. When the decoder accepts an instruction, it pulses the program counter's enable for exactly one cycle.

## Interface
- ADDR_WIDTH, 8, instruction address width; matches program counter width
- DATA_WIDTH, 8, memory byte width; instruction width is 2*DATA_WIDTH
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- pc_address  in  ADDR_WIDTH  current program counter value
- pc_enable  out  1  one-cycle pulse; program counter advances or jumps on this edge
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_WIDTH  memory byte address, stable while mem_req is high
- mem_ready  in  1  memory has completed the read; mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_WIDTH  read data
- instr  out  2*DATA_WIDTH  assembled instruction: [15:8] is the opcode byte at fetch_addr, [7:0] is the operand byte at fetch_addr+1
- instr_addr  out  ADDR_WIDTH  address of the first byte of instr
- instr_valid  out  1  instr and instr_addr are valid
- instr_ready  in  1  decoder accepts instr

## Operation
- States: FETCH_HI, FETCH_LO, HOLD. Reset state is FETCH_HI.
- FETCH_HI:
  - mem_req=1, mem_addr=pc_address.
  - On mem_ready: latch pc_address into fetch_addr and mem_rdata into instr[15:8], then go to FETCH_LO.
- FETCH_LO:
  - mem_req=1, mem_addr=fetch_addr+1, truncated to ADDR_WIDTH so that 8'hFF+1 wraps to 8'h00.
  - On mem_ready: latch mem_rdata into instr[7:0] and go to HOLD.
- HOLD:
  - instr_valid=1, mem_req=0.
  - When instr_ready=1: pc_enable=1 for that cycle and return to FETCH_HI.
  - Otherwise stay in HOLD with instr and instr_addr stable.
- pc_enable = (state==HOLD) && instr_ready. It is combinational from state and input. It is never high in any other state.
- The decoder drives the program counter's jump, jz and jump_address alongside instr_ready. The jump target is therefore applied on the same pc_enable edge. The fetcher does not redirect itself.
- pc_address is treated as stable outside the pc_enable edge. The fetcher uses the latched fetch_addr for the second byte and ignores later pc_address changes.
- No alignment check. Odd addresses are fetched as given.
- Reset mid-fetch:
  - The request is abandoned and mem_req drops while reset is high.
  - The memory must tolerate an abandoned request.
  - After release, fetching restarts in FETCH_HI from pc_address (8'h00 after PC reset).
- Reset values: state=FETCH_HI, fetch_addr=0, instr=16'h0000, instr_addr=0, instr_valid=0, pc_enable=0, mem_req=0, mem_addr=0.

## Timing
- mem_req, mem_addr and instr_valid are decoded from registered state. instr and instr_addr are registers.
- Zero-wait memory (mem_ready=1 on the first request cycle):
  - cycle 0 FETCH_HI
  - cycle 1 FETCH_LO
  - cycle 2 HOLD with instr_valid=1
  - If instr_ready=1 in cycle 2, pc_enable pulses and the next FETCH_HI is cycle 3.
  - Throughput is one instruction per 3 cycles.
- Each memory wait cycle adds one cycle to the corresponding fetch state. mem_addr stays constant through waits.
- instr_valid rises the cycle after the second mem_ready. It falls the cycle after the instr_ready/valid handshake.
- pc_address reflects the new PC in the first FETCH_HI cycle after pc_enable.
- mem_ready while mem_req=0 (HOLD) is ignored.

## Structure
- Shared package cpu_pkg: fetch_state_t enum (FETCH_HI, FETCH_LO, HOLD), INSTR_WIDTH=16, ADDR_WIDTH=8 constants.
- Single module with no sub-modules. The FSM, byte latches and address increment are small enough to stay flat.

## Test plan
- Reset, zero-wait memory returning bytes A0, 05 at addresses 00, 01; instr_ready=1 -> mem_addr 00 then 01; instr=16'hA005, instr_addr=00, instr_valid in cycle 2; pc_enable pulses in cycle 2 only.
- 2 wait cycles on each byte -> mem_addr held for 3 cycles per byte; instr_valid rises in cycle 6; no pc_enable before the handshake.
- Decoder backpressure: instr_ready=0 for 4 HOLD cycles -> instr stable, mem_req=0, pc_enable=0; the first cycle with instr_ready=1 gives a single pc_enable pulse.
- pc_address=8'hFF -> second request at mem_addr 8'h00; instr_addr=8'hFF.
- Reset asserted during FETCH_LO wait -> mem_req low immediately, instr_valid=0; after release mem_addr=00 in FETCH_HI.
- Back-to-back stream with a model program counter (+2 per pc_enable, jump to 8'h10 on the third instruction) -> fetch addresses 00, 02, 04, 10; each instruction is delivered exactly once.
